// File: rtl/lu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | lu_pkg: opcodes, FSM encoding and flag record for lu_serial_unit |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package lu_pkg;

   localparam logic [2:0] OP_LE       = 3'd0;
   localparam logic [2:0] OP_A_ODD    = 3'd1;
   localparam logic [2:0] OP_B_ODD    = 3'd2;
   localparam logic [2:0] OP_CARRY    = 3'd3;
   localparam logic [2:0] OP_LT       = 3'd4;
   localparam logic [2:0] OP_EQ       = 3'd5;
   localparam logic [2:0] OP_PARITY_A = 3'd6;
   localparam logic [2:0] OP_ZERO_A   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic carry;
      logic lt;
      logic eq;
      logic parity;
      logic nonzero;
   } flags_t;

   // eq starts true so it can be AND-accumulated across slices
   localparam flags_t FLAGS_INIT = '{carry: 1'b0, lt: 1'b0, eq: 1'b1,
                                     parity: 1'b0, nonzero: 1'b0};

   function automatic logic lu_eval(input logic [2:0] op, input flags_t f,
                                    input logic a0, input logic b0);
      logic r;
      r = 1'b0;
      case (op)
         OP_LE:       r = f.lt | f.eq;
         OP_A_ODD:    r = a0;
         OP_B_ODD:    r = b0;
         OP_CARRY:    r = f.carry;
         OP_LT:       r = f.lt;
         OP_EQ:       r = f.eq;
         OP_PARITY_A: r = f.parity;
         OP_ZERO_A:   r = ~f.nonzero;
         default:     r = 1'b0;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lu_serial_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | lu_serial_unit_if: request/response bus for lu_serial_unit       |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
interface lu_serial_unit_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       sel;
   logic             out_valid;
   logic             out_ready;
   logic             result;
   logic             busy;

   modport master (
      output in_valid, a, b, sel, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, a, b, sel, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface
`default_nettype wire

// File: rtl/lu_chunk_slice.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | lu_chunk_slice: combinational flag update for one operand slice  |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module lu_chunk_slice
   import lu_pkg::*;
#(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] slice_a_i,
   input  logic [CHUNK-1:0] slice_b_i,
   input  flags_t           flags_i,
   output flags_t           flags_o
);

   logic [CHUNK:0] sum_d;

   always_comb begin
      sum_d = {1'b0, slice_a_i} + {1'b0, slice_b_i} + {{CHUNK{1'b0}}, flags_i.carry};
      flags_o.carry   = sum_d[CHUNK];
      // Slices arrive LSB first, so the last differing slice decides lt
      flags_o.lt      = (slice_a_i != slice_b_i) ? (slice_a_i < slice_b_i) : flags_i.lt;
      flags_o.eq      = flags_i.eq & (slice_a_i == slice_b_i);
      flags_o.parity  = flags_i.parity ^ (^slice_a_i);
      flags_o.nonzero = flags_i.nonzero | (|slice_a_i);
   end

endmodule
`default_nettype wire

// File: rtl/lu_serial_unit.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | lu_serial_unit: chunk-serial compare/carry/parity logic unit     |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module lu_serial_unit
   import lu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  wire logic          clk,
   input  wire logic          rst,
   lu_serial_unit_if.slave    bus
);

   localparam int N     = WIDTH / CHUNK;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       sel_q;
   logic             a_lsb_q;
   logic             b_lsb_q;
   flags_t           flags_q;
   flags_t           flags_d;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             result_q;
   logic             busy_q;

   lu_chunk_slice #(
      .CHUNK (CHUNK)
   ) u_slice (
      .slice_a_i (a_q[CHUNK-1:0]),
      .slice_b_i (b_q[CHUNK-1:0]),
      .flags_i   (flags_q),
      .flags_o   (flags_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sel_q       <= '0;
         a_lsb_q     <= 1'b0;
         b_lsb_q     <= 1'b0;
         flags_q     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               in_ready_q <= 1'b1;
               // in_ready_q is low on the first edge out of reset, so no accept there
               if (bus.in_valid && in_ready_q) begin
                  a_q        <= bus.a;
                  b_q        <= bus.b;
                  sel_q      <= bus.sel;
                  a_lsb_q    <= bus.a[0];
                  b_lsb_q    <= bus.b[0];
                  flags_q    <= FLAGS_INIT;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               a_q     <= a_q >> CHUNK;
               b_q     <= b_q >> CHUNK;
               flags_q <= flags_d;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  result_q    <= lu_eval(sel_q, flags_d, a_lsb_q, b_lsb_q);
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_lu_serial_unit.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_lu_serial_unit: directed + random bench against a ref model   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_lu_serial_unit;

   localparam int WIDTH = 8;
   localparam int CHUNK = 2;
   localparam int N     = WIDTH / CHUNK;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   lu_serial_unit_if #(.WIDTH(WIDTH)) bus ();

   lu_serial_unit #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic ref_result(input logic [7:0] ra, input logic [7:0] rb,
                                       input logic [2:0] rs);
      int sa;
      int sb;
      sa = ra;
      sb = rb;
      case (rs)
         3'd0:    return sa <= sb;
         3'd1:    return (sa % 2) == 1;
         3'd2:    return (sb % 2) == 1;
         3'd3:    return (sa + sb) > 255;
         3'd4:    return sa < sb;
         3'd5:    return sa == sb;
         3'd6:    return ($countones(ra) % 2) == 1;
         default: return sa == 0;
      endcase
   endfunction

   // One full transaction; 'hold' cycles of out_ready low in DONE while new requests are waved
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] ts,
                         input int hold, input bit pester);
      int    guard;
      int    lat;
      logic  exp_r;
      logic  got_r;
      exp_r = ref_result(ta, tb_v, ts);
      guard = 0;
      while (!bus.in_ready && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check("ready_wait", 32'(guard < 20), 32'd1);
      bus.in_valid = 1'b1;
      bus.a        = ta;
      bus.b        = tb_v;
      bus.sel      = ts;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      do begin
         if (pester) begin
            bus.in_valid = 1'($urandom);
            bus.a        = 8'($urandom);
            bus.b        = 8'($urandom);
            bus.sel      = 3'($urandom);
         end
         bus.out_ready = 1'($urandom);
         @(posedge clk); #1;
         lat++;
         if (!bus.out_valid) begin
            check("busy_in_ready", 32'(bus.in_ready), 32'd0);
            check("busy_flag", 32'(bus.busy), 32'd1);
         end
      end while (!bus.out_valid && lat < 20);
      check("latency", 32'(lat), 32'(N));
      check($sformatf("result a=%0d b=%0d sel=%0d", ta, tb_v, ts), 32'(bus.result), 32'(exp_r));
      got_r = bus.result;
      bus.out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         bus.in_valid = 1'b1;
         bus.a        = 8'($urandom);
         bus.b        = 8'($urandom);
         bus.sel      = 3'($urandom);
         @(posedge clk); #1;
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_result", 32'(bus.result), 32'(got_r));
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("release_valid", 32'(bus.out_valid), 32'd0);
      check("release_in_ready", 32'(bus.in_ready), 32'd1);
      check("release_busy", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #100000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.sel       = '0;
      bus.out_ready = 1'b0;
      #3;
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_result", 32'(bus.result), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

      run_op(8'd5,   8'd9,   3'd0, 0, 1'b0);
      run_op(8'd5,   8'd9,   3'd4, 0, 1'b0);
      run_op(8'd200, 8'd100, 3'd3, 0, 1'b1);
      run_op(8'd100, 8'd100, 3'd3, 0, 1'b0);
      run_op(8'd100, 8'd100, 3'd5, 0, 1'b0);
      run_op(8'd100, 8'd100, 3'd0, 0, 1'b0);
      run_op(8'd100, 8'd100, 3'd4, 0, 1'b0);
      run_op(8'h81,  8'd0,   3'd1, 0, 1'b0);
      run_op(8'h07,  8'd0,   3'd6, 0, 1'b0);
      run_op(8'h00,  8'd0,   3'd7, 0, 1'b0);
      run_op(8'd0,   8'h10,  3'd2, 0, 1'b0);
      run_op(8'hFF,  8'h01,  3'd3, 3, 1'b1);
      run_op(8'hFF,  8'h00,  3'd3, 0, 1'b0);
      run_op(8'h80,  8'h7F,  3'd4, 0, 1'b0);

      // Abort mid-operation: no result may surface afterwards
      bus.in_valid = 1'b1;
      bus.a        = 8'd200;
      bus.b        = 8'd100;
      bus.sel      = 3'd3;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("abort_release_in_ready", 32'(bus.in_ready), 32'd1);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         check("abort_no_result", 32'(bus.out_valid), 32'd0);
      end
      run_op(8'd1, 8'd2, 3'd4, 0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         run_op(8'($urandom), 8'($urandom), 3'($urandom), int'($urandom_range(0, 3)), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lu_serial_unit.md
LU_SERIAL_UNIT -- requirements
Module: lu_serial_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits; legal values are multiples of CHUNK and at least CHUNK.
REQ-002 The block SHALL have parameter CHUNK, default 2, bits processed per cycle; N = WIDTH/CHUNK is the pass count.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 in_valid  in  1  operand/opcode presented.
REQ-006 in_ready  out  1  block can accept; high only in IDLE.
REQ-007 a  in  WIDTH  operand A, unsigned.
REQ-008 b  in  WIDTH  operand B, unsigned.
REQ-009 sel  in  3  opcode; 0 LE(a<=b), 1 A_ODD(a[0]), 2 B_ODD(b[0]), 3 CARRY(a+b > 2^WIDTH-1), 4 LT(a<b), 5 EQ(a==b), 6 PARITY_A(xor of a), 7 ZERO_A(a==0).
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 result  out  1  1-bit outcome of the captured opcode.
REQ-013 busy  out  1  high in BUSY or DONE.

Function
REQ-014 An accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; a, b, sel SHALL be latched at that edge and later input changes SHALL be ignored.
REQ-015 FSM states SHALL be IDLE, BUSY, DONE; IDLE->BUSY on accept; BUSY->DONE after the N-th chunk; DONE->IDLE on out_ready=1; no other transitions.
REQ-016 In BUSY the block SHALL consume one CHUNK-bit slice of each latched operand per cycle, LSB slice first, using a chunk counter 0..N-1.
REQ-017 Per slice the block SHALL update running flags: carry (slice sum plus carry-in), lt (set to slice_a<slice_b when slices differ, else hold), eq (AND of slice equality), parity (XOR), nonzero (OR of a).
REQ-018 The carry chain SHALL be WIDTH+1 bits wide in effect; CARRY result is the final carry-out.
REQ-019 A_ODD and B_ODD SHALL use bit 0 of the latched operands but SHALL observe the same N-cycle latency as all other opcodes.
REQ-020 out_valid SHALL rise exactly N cycles after the accept edge and result SHALL be stable while out_valid=1.
REQ-021 out_valid and result SHALL hold until an edge with out_ready=1; the block SHALL then return to IDLE with out_valid=0.
REQ-022 in_valid asserted in BUSY or DONE SHALL NOT be accepted; minimum accept-to-accept spacing is N+2 cycles with out_ready held high.
REQ-023 out_ready asserted outside DONE SHALL have no effect.
REQ-024 For WIDTH=CHUNK (N=1) out_valid SHALL rise one cycle after accept.

Reset
REQ-025 While rst=1: state IDLE, chunk counter 0, all flags 0, out_valid 0, result 0, busy 0, in_ready 0.
REQ-026 in_ready SHALL be 1 from the first edge after rst deasserts.
REQ-027 Reset in BUSY or DONE SHALL abort the operation; no result for it SHALL ever be presented.

Structure
REQ-028 Package lu_pkg SHALL hold the 3-bit opcode constants and the FSM state encoding.
REQ-029 One sub-module lu_chunk_slice SHALL implement the combinational per-slice flag update; the top instantiates it once and holds FSM, counter, and operand shift registers.

Verification (WIDTH=8, CHUNK=2, N=4)
REQ-030 a=5,b=9, sel=0 then sel=4 -> result=1 both, out_valid exactly 4 cycles after each accept.
REQ-031 a=200,b=100 sel=3 -> result=1; a=100,b=100 sel=3 -> 0, sel=5 -> 1, sel=0 -> 1, sel=4 -> 0.
REQ-032 a=0x81 sel=1 -> 1; a=0x07 sel=6 -> 1; a=0x00 sel=7 -> 1; b=0x10 sel=2 -> 0.
REQ-033 out_ready low 3 cycles in DONE with in_valid=1 and new operands -> result held, in_ready=0, new operands not accepted; accepted in the cycle after return to IDLE.
REQ-034 rst pulsed at chunk 2 of a sel=3 operation -> out_valid never rises for it, in_ready=1 after release, next operation a=1,b=2 sel=4 returns 1.
